// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: prioritised redirects, valid/ready fetch issue, stall support.
// Optional macro PC_ALIGN_CHECK_EN rejects misaligned redirect targets and reports them.
module pc_sequencer #(
  parameter int unsigned       WIDTH      = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC  = 32'h00000060,
  parameter int unsigned       INC        = 4,
  parameter int unsigned       ALIGN_BITS = 2,
  parameter int unsigned       NUM_REDIR  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REDIR-1:0]       redir_valid,
  input  logic [NUM_REDIR*WIDTH-1:0] redir_target,
  input  logic                       stall,
  output logic                       req_valid,
  output logic [WIDTH-1:0]           req_addr,
  input  logic                       req_ready,
  output logic [WIDTH-1:0]           pc,
  output logic                       misalign_err,
  output logic [WIDTH-1:0]           misalign_addr
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             sel_valid_s;
  logic [WIDTH-1:0] sel_target_s;
  logic             use_valid_s;
  logic [WIDTH-1:0] use_target_s;

  // Priority select: scanning downward lets the lowest asserted index win.
  always_comb begin
    sel_valid_s  = 1'b0;
    sel_target_s = '0;
    for (int i = int'(NUM_REDIR) - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        sel_valid_s  = 1'b1;
        sel_target_s = redir_target[i*WIDTH +: WIDTH];
      end else begin
        sel_valid_s  = sel_valid_s;
        sel_target_s = sel_target_s;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic             mis_s;
  logic             misalign_err_q, misalign_err_d;
  logic [WIDTH-1:0] misalign_addr_q, misalign_addr_d;

  // Misaligned targets are dropped and reported instead of being used.
  always_comb begin
    mis_s           = sel_valid_s && (|(sel_target_s & ALIGN_MASK));
    use_valid_s     = sel_valid_s && !mis_s;
    use_target_s    = sel_target_s;
    misalign_err_d  = mis_s;
    if (mis_s) begin
      misalign_addr_d = sel_target_s;
    end else begin
      misalign_addr_d = misalign_addr_q;
    end
  end

  // Error report registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      misalign_err_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_err_q  <= misalign_err_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign misalign_err  = misalign_err_q;
  assign misalign_addr = misalign_addr_q;
`else
  // Without checking, the alignment bits are simply cleared.
  always_comb begin
    use_valid_s  = sel_valid_s;
    use_target_s = sel_target_s & ~ALIGN_MASK;
  end

  assign misalign_err  = 1'b0;
  assign misalign_addr = '0;
`endif

  // State register and PC/pending datapath flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VEC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Next-state: a fetch address only advances on handshake or while no request is open.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    case (state_q)
      ST_BOOT, ST_HALT: begin
        if (use_valid_s) begin
          pc_d = use_target_s;
        end else if (pend_valid_q) begin
          pc_d = pend_target_q;
        end else begin
          pc_d = pc_q;
        end
        pend_valid_d = 1'b0;
        state_d      = stall ? ST_HALT : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (req_ready) begin
          if (use_valid_s) begin
            pc_d = use_target_s;
          end else if (pend_valid_q) begin
            pc_d = pend_target_q;
          end else begin
            pc_d = pc_q + INC_W;
          end
          pend_valid_d = 1'b0;
          state_d      = stall ? ST_HALT : ST_ISSUE;
        end else if (use_valid_s) begin
          // Request stays open; the newest redirect waits for the handshake.
          pend_valid_d  = 1'b1;
          pend_target_d = use_target_s;
        end else begin
          pend_valid_d  = pend_valid_q;
        end
      end
      default: begin
        state_d      = ST_BOOT;
        pend_valid_d = 1'b0;
      end
    endcase
  end

  // Outputs come straight from flops.
  always_comb begin
    req_valid = (state_q == ST_ISSUE);
    req_addr  = pc_q;
    pc        = pc_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  redir_valid;
  logic [63:0] redir_target;
  logic        stall;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic [31:0] pc;
  logic        misalign_err;
  logic [31:0] misalign_addr;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: "open request" flag, PC, and a single-slot pending redirect.
  logic [31:0] m_pc;
  bit          m_open;
  logic [31:0] m_pend[$];
  bit          m_err;
  logic [31:0] m_eaddr;

  pc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .redir_valid   (redir_valid),
    .redir_target  (redir_target),
    .stall         (stall),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .pc            (pc),
    .misalign_err  (misalign_err),
    .misalign_addr (misalign_addr)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int          win;
    logic [31:0] t;
    bit          redir;
    if (!rst) begin
      m_pc    = 32'h60;
      m_open  = 1'b0;
      m_pend.delete();
      m_err   = 1'b0;
      m_eaddr = 32'h0;
      return;
    end
    win   = -1;
    redir = 1'b0;
    t     = 32'h0;
    m_err = 1'b0;
    for (int i = 0; i < 2; i++) if (redir_valid[i] && win < 0) win = i;
    if (win >= 0) begin
      t = redir_target[win*32 +: 32];
`ifdef PC_ALIGN_CHECK_EN
      if (t % 4 != 0) begin
        m_err   = 1'b1;
        m_eaddr = t;
      end else begin
        redir = 1'b1;
      end
`else
      t     = t - (t % 4);
      redir = 1'b1;
`endif
    end
    if (m_open) begin
      if (req_ready) begin
        if (redir) m_pc = t;
        else if (m_pend.size() > 0) m_pc = m_pend[0];
        else m_pc = m_pc + 32'd4;
        m_pend.delete();
        m_open = !stall;
      end else if (redir) begin
        m_pend.delete();
        m_pend.push_back(t);
      end
    end else begin
      if (redir) m_pc = t;
      else if (m_pend.size() > 0) m_pc = m_pend[0];
      m_pend.delete();
      m_open = !stall;
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic r, input logic [1:0] rv, input logic [31:0] t0,
                       input logic [31:0] t1, input logic st, input logic rdy);
    rst          = r;
    redir_valid  = rv;
    redir_target = {t1, t0};
    stall        = st;
    req_ready    = rdy;
  endtask

  task automatic test_reset();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if (req_valid !== 1'b0 || pc !== 32'h60 || misalign_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset cyc%0d: req_valid=%b pc=%h err=%b, expected 0/00000060/0", i, req_valid, pc, misalign_err);
      end
    end
    rst = 1'b1;
    tests_run++;
    if (req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL boot_bubble: req_valid=%b expected 0", req_valid);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if (req_valid !== 1'b1 || req_addr !== 32'h60 + 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL sequential %0d: valid=%b addr=%h expected 1/%h", i, req_valid, req_addr, 32'h60 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] rv_seq [3] = '{2'b00, 2'b10, 2'b00};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rv_seq[i], 32'h0, 32'h200, 1'b0, 1'b0);
      cycle();
      tests_run++;
      if (req_valid !== 1'b1 || req_addr !== 32'h68) begin
        tests_failed++;
        $display("FAIL backpressure_hold %0d: valid=%b addr=%h expected 1/00000068", i, req_valid, req_addr);
      end
    end
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle();
    tests_run++;
    if (req_valid !== 1'b1 || req_addr !== 32'h200) begin
      tests_failed++;
      $display("FAIL backpressure_pending: valid=%b addr=%h expected 1/00000200", req_valid, req_addr);
    end
  endtask

  task automatic test_priority();
    drive(1'b1, 2'b11, 32'h300, 32'h400, 1'b0, 1'b1);
    cycle();
    tests_run++;
    if (req_addr !== 32'h300) begin
      tests_failed++;
      $display("FAIL priority: addr=%h expected 00000300", req_addr);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 2'b01, 32'h80, 32'h0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle();
      tests_run++;
      if (req_valid !== 1'b0 || pc !== 32'h84) begin
        tests_failed++;
        $display("FAIL stall_hold %0d: valid=%b pc=%h expected 0/00000084", i, req_valid, pc);
      end
    end
    drive(1'b1, 2'b01, 32'h500, 32'h0, 1'b1, 1'b1);
    cycle();
    tests_run++;
    if (req_valid !== 1'b0 || pc !== 32'h500) begin
      tests_failed++;
      $display("FAIL stall_redirect: valid=%b pc=%h expected 0/00000500", req_valid, pc);
    end
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle();
    tests_run++;
    if (req_valid !== 1'b1 || req_addr !== 32'h500) begin
      tests_failed++;
      $display("FAIL stall_release: valid=%b addr=%h expected 1/00000500", req_valid, req_addr);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle();
    tests_run++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap: valid=%b addr=%h expected 1/00000000", req_valid, req_addr);
    end
  endtask

  task automatic test_align();
    logic [31:0] exp_pc0, exp_pc1, exp_ea;
    logic        exp_err;
`ifdef PC_ALIGN_CHECK_EN
    exp_pc0 = 32'h4;   exp_pc1 = 32'h8;   exp_err = 1'b1; exp_ea = 32'h102;
`else
    exp_pc0 = 32'h100; exp_pc1 = 32'h104; exp_err = 1'b0; exp_ea = 32'h0;
`endif
    drive(1'b1, 2'b01, 32'h102, 32'h0, 1'b0, 1'b1);
    cycle();
    tests_run++;
    if (req_addr !== exp_pc0 || misalign_err !== exp_err || misalign_addr !== exp_ea) begin
      tests_failed++;
      $display("FAIL align: addr=%h err=%b eaddr=%h expected %h/%b/%h", req_addr, misalign_err, misalign_addr, exp_pc0, exp_err, exp_ea);
    end
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle();
    tests_run++;
    if (req_addr !== exp_pc1 || misalign_err !== 1'b0 || misalign_addr !== exp_ea) begin
      tests_failed++;
      $display("FAIL align_after: addr=%h err=%b eaddr=%h expected %h/0/%h", req_addr, misalign_err, misalign_addr, exp_pc1, exp_ea);
    end
  endtask

  task automatic test_random();
    logic [31:0] t0, t1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    for (int n = 0; n < 600; n++) begin
      t0 = $urandom();
      t1 = $urandom();
      if ($urandom_range(3, 0) != 0) t0[1:0] = 2'b00;
      if ($urandom_range(3, 0) != 0) t1[1:0] = 2'b00;
      drive(($urandom_range(49, 0) != 0), 2'($urandom_range(3, 0) == 0 ? $urandom_range(3, 1) : 0),
            t0, t1, ($urandom_range(3, 0) == 0), ($urandom_range(9, 0) < 6));
      cycle();
      tests_run++;
      if (req_valid !== m_open || req_addr !== m_pc || pc !== m_pc ||
          misalign_err !== m_err || misalign_addr !== m_eaddr) begin
        tests_failed++;
        $display("FAIL random cyc%0d: valid=%b addr=%h pc=%h err=%b ea=%h expected %b/%h/%h/%b/%h",
                 n, req_valid, req_addr, pc, misalign_err, misalign_addr, m_open, m_pc, m_pc, m_err, m_eaddr);
      end
    end
  endtask

  initial begin
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    m_pc = 32'h60; m_open = 1'b0; m_err = 1'b0; m_eaddr = 32'h0;
    #1;
    test_reset();
    test_backpressure();
    test_priority();
    test_stall();
    test_wrap();
    test_align();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
